// File: rtl/axi_vga_reg_slave_if.sv
// rtl/axi_vga_reg_slave_if.sv - AXI4-Lite bus bundle between the processor/VIP and the VGA register slave
interface axi_vga_reg_slave_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   S_AXI_AWADDR;
  logic [2:0]              S_AXI_AWPROT;
  logic                    S_AXI_AWVALID;
  logic                    S_AXI_AWREADY;
  logic [DATA_WIDTH-1:0]   S_AXI_WDATA;
  logic [DATA_WIDTH/8-1:0] S_AXI_WSTRB;
  logic                    S_AXI_WVALID;
  logic                    S_AXI_WREADY;
  logic [1:0]              S_AXI_BRESP;
  logic                    S_AXI_BVALID;
  logic                    S_AXI_BREADY;
  logic [ADDR_WIDTH-1:0]   S_AXI_ARADDR;
  logic [2:0]              S_AXI_ARPROT;
  logic                    S_AXI_ARVALID;
  logic                    S_AXI_ARREADY;
  logic [DATA_WIDTH-1:0]   S_AXI_RDATA;
  logic [1:0]              S_AXI_RRESP;
  logic                    S_AXI_RVALID;
  logic                    S_AXI_RREADY;

  modport slave (
    input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
    output S_AXI_AWREADY,
    input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    output S_AXI_WREADY,
    output S_AXI_BRESP, S_AXI_BVALID,
    input  S_AXI_BREADY,
    input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
    output S_AXI_ARREADY,
    output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
    input  S_AXI_RREADY
  );

  modport master (
    output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
    input  S_AXI_AWREADY,
    output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    input  S_AXI_WREADY,
    input  S_AXI_BRESP, S_AXI_BVALID,
    output S_AXI_BREADY,
    output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
    input  S_AXI_ARREADY,
    input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
    output S_AXI_RREADY
  );
endinterface

// File: rtl/axi_vga_reg_slave.sv
// rtl/axi_vga_reg_slave.sv - AXI4-Lite register file driving the VGA text-editor control words
// Optional per-register commit pulse output enabled by AXI_VGA_REG_WR_STROBE_EN.
module axi_vga_reg_slave #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4,
  parameter int NUM_REGS   = 4
) (
  input  logic                           S_AXI_ACLK,
  input  logic                           S_AXI_ARESETN,
  axi_vga_reg_slave_if.slave             s_axi,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out
`ifdef AXI_VGA_REG_WR_STROBE_EN
  ,
  output logic [NUM_REGS-1:0]            wr_strobe
`endif
);
  localparam int IDX_W  = ADDR_WIDTH - 2;
  localparam int STRB_W = DATA_WIDTH / 8;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {W_IDLE, W_RESP} wstate_e;
  typedef enum logic {R_IDLE, R_DATA} rstate_e;

  wstate_e               wstate_q, wstate_d;
  rstate_e               rstate_q, rstate_d;
  logic                  aw_held_q, aw_held_d, w_held_q, w_held_d;
  logic                  awready_q, awready_d, wready_q, wready_d;
  logic                  bvalid_q, bvalid_d;
  logic [1:0]            bresp_q, bresp_d;
  logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0]     wstrb_q, wstrb_d;
  logic                  arready_q, arready_d, rvalid_q, rvalid_d;
  logic [1:0]            rresp_q, rresp_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
  logic [NUM_REGS-1:0]   wr_hit;

  // A half captured on an earlier edge wins over the live bus for that half
  logic                  aw_fire, w_fire, ar_fire;
  logic [ADDR_WIDTH-1:0] addr_eff;
  logic [DATA_WIDTH-1:0] data_eff;
  logic [STRB_W-1:0]     strb_eff;
  logic [IDX_W-1:0]      w_idx, r_idx;
  logic                  w_in_range, r_in_range;

  assign aw_fire    = s_axi.S_AXI_AWVALID & awready_q;
  assign w_fire     = s_axi.S_AXI_WVALID & wready_q;
  assign ar_fire    = s_axi.S_AXI_ARVALID & arready_q;
  assign addr_eff   = aw_held_q ? awaddr_q : s_axi.S_AXI_AWADDR;
  assign data_eff   = w_held_q ? wdata_q : s_axi.S_AXI_WDATA;
  assign strb_eff   = w_held_q ? wstrb_q : s_axi.S_AXI_WSTRB;
  assign w_idx      = addr_eff[ADDR_WIDTH-1:2];
  assign r_idx      = s_axi.S_AXI_ARADDR[ADDR_WIDTH-1:2];
  assign w_in_range = ({1'b0, w_idx} < (IDX_W+1)'(NUM_REGS));
  assign r_in_range = ({1'b0, r_idx} < (IDX_W+1)'(NUM_REGS));

  logic unused_ok;
  assign unused_ok = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT, addr_eff[1:0], s_axi.S_AXI_ARADDR[1:0]};

  always_comb begin
    wstate_d  = wstate_q;
    aw_held_d = aw_held_q;
    w_held_d  = w_held_q;
    awready_d = awready_q;
    wready_d  = wready_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    regs_d    = regs_q;
    wr_hit    = '0;
    unique case (wstate_q)
      W_IDLE: begin
        if (aw_fire) begin
          aw_held_d = 1'b1;
          awaddr_d  = s_axi.S_AXI_AWADDR;
        end
        if (w_fire) begin
          w_held_d = 1'b1;
          wdata_d  = s_axi.S_AXI_WDATA;
          wstrb_d  = s_axi.S_AXI_WSTRB;
        end
        if ((aw_held_q | aw_fire) && (w_held_q | w_fire)) begin
          for (int k = 0; k < NUM_REGS; k++) begin
            if (w_idx == IDX_W'(k)) begin
              wr_hit[k] = 1'b1;
              for (int b = 0; b < STRB_W; b++) begin
                if (strb_eff[b]) regs_d[k][8*b +: 8] = data_eff[8*b +: 8];
              end
            end
          end
          aw_held_d = 1'b0;
          w_held_d  = 1'b0;
          awready_d = 1'b0;
          wready_d  = 1'b0;
          bvalid_d  = 1'b1;
          bresp_d   = w_in_range ? RESP_OKAY : RESP_SLVERR;
          wstate_d  = W_RESP;
        end else begin
          awready_d = ~(aw_held_q | aw_fire);
          wready_d  = ~(w_held_q | w_fire);
        end
      end
      W_RESP: begin
        if (s_axi.S_AXI_BREADY) begin
          bvalid_d  = 1'b0;
          bresp_d   = RESP_OKAY;
          awready_d = 1'b1;
          wready_d  = 1'b1;
          wstate_d  = W_IDLE;
        end
      end
      default: wstate_d = W_IDLE;
    endcase
  end

  // Reads sample regs_q, so a same-edge write commit is not yet visible
  always_comb begin
    rstate_d  = rstate_q;
    arready_d = arready_q;
    rvalid_d  = rvalid_q;
    rresp_d   = rresp_q;
    rdata_d   = rdata_q;
    unique case (rstate_q)
      R_IDLE: begin
        arready_d = 1'b1;
        if (ar_fire) begin
          rdata_d = '0;
          for (int k = 0; k < NUM_REGS; k++) begin
            if (r_idx == IDX_W'(k)) rdata_d = regs_q[k];
          end
          rresp_d   = r_in_range ? RESP_OKAY : RESP_SLVERR;
          rvalid_d  = 1'b1;
          arready_d = 1'b0;
          rstate_d  = R_DATA;
        end
      end
      R_DATA: begin
        if (s_axi.S_AXI_RREADY) begin
          rvalid_d  = 1'b0;
          arready_d = 1'b1;
          rstate_d  = R_IDLE;
        end
      end
      default: rstate_d = R_IDLE;
    endcase
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      wstate_q  <= W_IDLE;
      rstate_q  <= R_IDLE;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rresp_q   <= RESP_OKAY;
      rdata_q   <= '0;
      regs_q    <= '{default: '0};
    end else begin
      wstate_q  <= wstate_d;
      rstate_q  <= rstate_d;
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rresp_q   <= rresp_d;
      rdata_q   <= rdata_d;
      regs_q    <= regs_d;
    end
  end

`ifdef AXI_VGA_REG_WR_STROBE_EN
  logic [NUM_REGS-1:0] wr_strobe_q, wr_strobe_d;

  always_comb begin
    wr_strobe_d = wr_hit;
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) wr_strobe_q <= '0;
    else                wr_strobe_q <= wr_strobe_d;
  end

  assign wr_strobe = wr_strobe_q;
`else
  logic unused_hit;
  assign unused_hit = ^wr_hit;
`endif

  assign s_axi.S_AXI_AWREADY = awready_q;
  assign s_axi.S_AXI_WREADY  = wready_q;
  assign s_axi.S_AXI_BVALID  = bvalid_q;
  assign s_axi.S_AXI_BRESP   = bresp_q;
  assign s_axi.S_AXI_ARREADY = arready_q;
  assign s_axi.S_AXI_RVALID  = rvalid_q;
  assign s_axi.S_AXI_RRESP   = rresp_q;
  assign s_axi.S_AXI_RDATA   = rdata_q;

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg_out
    assign reg_out[g*DATA_WIDTH +: DATA_WIDTH] = regs_q[g];
  end
endmodule

// File: tb/tb_axi_vga_reg_slave.sv
// tb/tb_axi_vga_reg_slave.sv - randomized model-checked bench driving a 4-register and a 3-register slave in lockstep
module tb_axi_vga_reg_slave;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  awaddr = '0, araddr = '0, wstrb = '0;
  logic [31:0] wdata = '0;
  logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b1, arvalid = 1'b0, rready = 1'b1;
  logic [127:0] reg_out4;
  logic [95:0]  reg_out3;
`ifdef AXI_VGA_REG_WR_STROBE_EN
  logic [3:0] wr_strobe4;
  logic [2:0] wr_strobe3;
`endif

  always #5 clk = ~clk;

  axi_vga_reg_slave_if #(.ADDR_WIDTH(4), .DATA_WIDTH(32)) bus4 ();
  axi_vga_reg_slave_if #(.ADDR_WIDTH(4), .DATA_WIDTH(32)) bus3 ();

  assign bus4.S_AXI_AWADDR = awaddr;  assign bus3.S_AXI_AWADDR = awaddr;
  assign bus4.S_AXI_AWPROT = 3'b0;    assign bus3.S_AXI_AWPROT = 3'b0;
  assign bus4.S_AXI_AWVALID = awvalid; assign bus3.S_AXI_AWVALID = awvalid;
  assign bus4.S_AXI_WDATA = wdata;    assign bus3.S_AXI_WDATA = wdata;
  assign bus4.S_AXI_WSTRB = wstrb;    assign bus3.S_AXI_WSTRB = wstrb;
  assign bus4.S_AXI_WVALID = wvalid;  assign bus3.S_AXI_WVALID = wvalid;
  assign bus4.S_AXI_BREADY = bready;  assign bus3.S_AXI_BREADY = bready;
  assign bus4.S_AXI_ARADDR = araddr;  assign bus3.S_AXI_ARADDR = araddr;
  assign bus4.S_AXI_ARPROT = 3'b0;    assign bus3.S_AXI_ARPROT = 3'b0;
  assign bus4.S_AXI_ARVALID = arvalid; assign bus3.S_AXI_ARVALID = arvalid;
  assign bus4.S_AXI_RREADY = rready;  assign bus3.S_AXI_RREADY = rready;

  axi_vga_reg_slave #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .NUM_REGS(4)) dut4 (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n), .s_axi(bus4.slave), .reg_out(reg_out4)
`ifdef AXI_VGA_REG_WR_STROBE_EN
    , .wr_strobe(wr_strobe4)
`endif
  );

  axi_vga_reg_slave #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .NUM_REGS(3)) dut3 (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n), .s_axi(bus3.slave), .reg_out(reg_out3)
`ifdef AXI_VGA_REG_WR_STROBE_EN
    , .wr_strobe(wr_strobe3)
`endif
  );

  logic [31:0] m4 [4];
  logic [31:0] m3 [3];
  int n_checks = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [127:0] exp_out4();
    return {m4[3], m4[2], m4[1], m4[0]};
  endfunction

  function automatic logic [95:0] exp_out3();
    return {m3[2], m3[1], m3[0]};
  endfunction

  task automatic clear_model();
    for (int i = 0; i < 4; i++) m4[i] = '0;
    for (int i = 0; i < 3; i++) m3[i] = '0;
  endtask

  // lead > 0: W goes out lead cycles before AW; lead < 0: AW first
  task automatic do_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int lead, input int bp);
    bit aw_done, w_done, aw_hs, w_hs;
    int cyc;
    int idx;
    idx = int'(a[3:2]);
    @(negedge clk);
    awaddr = a; wdata = d; wstrb = s;
    bready = (bp == 0);
    awvalid = (lead <= 0);
    wvalid = (lead >= 0);
    aw_done = 0; w_done = 0; cyc = 0;
    while (!(aw_done && w_done) && cyc < 50) begin
      aw_hs = awvalid && bus4.S_AXI_AWREADY;
      w_hs = wvalid && bus4.S_AXI_WREADY;
      @(negedge clk);
      cyc++;
      if (aw_hs) begin awvalid = 0; aw_done = 1; end
      if (w_hs) begin wvalid = 0; w_done = 1; end
      if (!aw_done && !awvalid && cyc >= lead) awvalid = 1;
      if (!w_done && !wvalid && cyc >= -lead) wvalid = 1;
      if (aw_done != w_done) begin
        chk("wr_half_no_bvalid", bus4.S_AXI_BVALID, 0);
        if (w_done) chk("wr_wready_drop", bus4.S_AXI_WREADY, 0);
        else chk("wr_awready_drop", bus4.S_AXI_AWREADY, 0);
      end
    end
    if (!(aw_done && w_done)) begin
      chk("wr_timeout", 0, 1);
      awvalid = 0; wvalid = 0; bready = 1;
      return;
    end
    for (int b = 0; b < 4; b++) begin
      if (s[b]) begin
        m4[idx][8*b +: 8] = d[8*b +: 8];
        if (idx < 3) m3[idx][8*b +: 8] = d[8*b +: 8];
      end
    end
    chk("wr_bvalid", bus4.S_AXI_BVALID, 1);
    chk("wr_bresp4", bus4.S_AXI_BRESP, 2'b00);
    chk("wr_bresp3", bus3.S_AXI_BRESP, (idx < 3) ? 2'b00 : 2'b10);
    chk("wr_regout4", reg_out4, exp_out4());
    chk("wr_regout3", reg_out3, exp_out3());
`ifdef AXI_VGA_REG_WR_STROBE_EN
    chk("wr_strobe4", wr_strobe4, 4'(1 << idx));
    chk("wr_strobe3", wr_strobe3, (idx < 3) ? 3'(1 << idx) : 3'b0);
`endif
    for (int i = 0; i < bp; i++) begin
      @(negedge clk);
      chk("bp_bvalid_held", bus4.S_AXI_BVALID, 1);
      chk("bp_awready_low", bus4.S_AXI_AWREADY, 0);
    end
    bready = 1;
    @(negedge clk);
    chk("wr_bvalid_clr", bus4.S_AXI_BVALID, 0);
    chk("wr_awready_back", bus4.S_AXI_AWREADY, 1);
`ifdef AXI_VGA_REG_WR_STROBE_EN
    chk("wr_strobe_clr", wr_strobe4, 4'b0);
`endif
  endtask

  task automatic do_read(input logic [3:0] a, input int rbp, output logic [31:0] got);
    logic [31:0] e4, e3;
    int cyc;
    int idx;
    idx = int'(a[3:2]);
    got = '0;
    @(negedge clk);
    araddr = a; arvalid = 1; rready = (rbp == 0);
    cyc = 0;
    while (!bus4.S_AXI_ARREADY && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    if (!bus4.S_AXI_ARREADY) begin
      chk("rd_timeout", 0, 1);
      arvalid = 0; rready = 1;
      return;
    end
    e4 = m4[idx];
    e3 = '0;
    if (idx < 3) e3 = m3[idx];
    @(negedge clk);
    arvalid = 0;
    chk("rd_rvalid", bus4.S_AXI_RVALID, 1);
    chk("rd_arready_low", bus4.S_AXI_ARREADY, 0);
    chk("rd_data4", bus4.S_AXI_RDATA, e4);
    chk("rd_resp4", bus4.S_AXI_RRESP, 2'b00);
    chk("rd_data3", bus3.S_AXI_RDATA, e3);
    chk("rd_resp3", bus3.S_AXI_RRESP, (idx < 3) ? 2'b00 : 2'b10);
    got = bus4.S_AXI_RDATA;
    for (int i = 0; i < rbp; i++) begin
      @(negedge clk);
      chk("rbp_rvalid_held", bus4.S_AXI_RVALID, 1);
      chk("rbp_rdata_stable", bus4.S_AXI_RDATA, e4);
    end
    rready = 1;
    @(negedge clk);
    chk("rd_rvalid_clr", bus4.S_AXI_RVALID, 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] got, got2, d;
    logic [3:0]  a, a2, s;
    int op, lead, bp;
    clear_model();
    repeat (2) @(negedge clk);
    chk("rst_awready", bus4.S_AXI_AWREADY, 0);
    chk("rst_bvalid", bus4.S_AXI_BVALID, 0);
    chk("rst_rvalid", bus4.S_AXI_RVALID, 0);
    chk("rst_rdata", bus4.S_AXI_RDATA, 0);
    chk("rst_regout", reg_out4, 0);
    rst_n = 1;
    #1 chk("rel_arready_pre", bus4.S_AXI_ARREADY, 0);
    @(negedge clk);
    chk("rel_ready_all", {bus4.S_AXI_AWREADY, bus4.S_AXI_WREADY, bus4.S_AXI_ARREADY}, 3'b111);

    for (int i = 0; i < 4; i++) do_write(4'(i * 4), 32'(i + 1), 4'hF, 0, 0);
    for (int i = 0; i < 4; i++) begin
      do_read(4'(i * 4), 0, got);
      chk("seq_read", got, 32'(i + 1));
    end
    chk("seq_regout", reg_out4, 128'h00000004_00000003_00000002_00000001);
    chk("oor_regs_unchanged3", reg_out3, 96'h00000003_00000002_00000001);

    do_write(4'h8, 32'hAABBCCDD, 4'hF, 3, 0);
    chk("stagger_reg2", reg_out4[95:64], 32'hAABBCCDD);

    do_write(4'h4, 32'h11223344, 4'hF, 0, 0);
    do_write(4'h4, 32'hFFFFFFFF, 4'b0101, -2, 0);
    do_read(4'h4, 0, got);
    chk("strobe_read", got, 32'h11FF33FF);

    fork
      do_write(4'h4, 32'h5A5A5A5A, 4'hF, 0, 5);
      begin
        repeat (2) @(negedge clk);
        do_read(4'h0, 0, got);
        chk("conc_read_val", got, 32'h1);
        chk("conc_bvalid_still", bus4.S_AXI_BVALID, 1);
      end
    join

    fork
      do_write(4'h0, 32'h9, 4'hF, 0, 0);
      do_read(4'h0, 0, got);
    join
    chk("collide_old", got, 32'h1);
    do_read(4'h0, 0, got);
    chk("collide_new", got, 32'h9);

    for (int it = 0; it < 40; it++) begin
      op = int'($urandom_range(0, 2));
      a = 4'($urandom_range(0, 15));
      d = $urandom;
      s = 4'($urandom_range(0, 15));
      lead = int'($urandom_range(0, 6)) - 3;
      bp = int'($urandom_range(0, 3));
      if (op == 0) do_write(a, d, s, lead, bp);
      else if (op == 1) do_read(a, bp, got);
      else begin
        a2 = {a[3:2] + 2'd1, a[1:0]};
        fork
          do_write(a, d, s, lead, bp);
          do_read(a2, int'($urandom_range(0, 3)), got2);
        join
      end
    end

    @(negedge clk);
    awaddr = 4'h0; wdata = 32'hDEADBEEF; wstrb = 4'hF; awvalid = 1; wvalid = 1; bready = 0;
    @(negedge clk);
    awvalid = 0; wvalid = 0;
    chk("mid_bvalid_pre", bus4.S_AXI_BVALID, 1);
    #2 rst_n = 0;
    #1;
    chk("mid_bvalid_async", bus4.S_AXI_BVALID, 0);
    chk("mid_regout4_async", reg_out4, 0);
    chk("mid_regout3_async", reg_out3, 0);
`ifdef AXI_VGA_REG_WR_STROBE_EN
    chk("mid_strobe_async", wr_strobe4, 0);
`endif
    clear_model();
    bready = 1;
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    chk("mid_arready_rel", bus4.S_AXI_ARREADY, 1);
    chk("mid_no_bvalid", bus4.S_AXI_BVALID, 0);
    do_write(4'hC, 32'h13572468, 4'hF, 0, 0);
    do_read(4'hC, 1, got);
    chk("post_rst_read", got, 32'h13572468);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/axi_vga_reg_slave.md
Name: axi_vga_reg_slave

Overview:
- AXI4-Lite responder (slave) register file for the VGA text-editor IP; the target side of the AXI4-Lite master traffic issued by the processor or VIP.
- Holds NUM_REGS 32-bit control words: control, foreground colour, background colour, cursor and similar. Drives them as a flat bus to the VGA pixel/text logic.
- Write and read channels run independent state machines, so one read and one write may be in flight together.

Parameters:
- DATA_WIDTH, 32, AXI data width; only 32 is supported.
- ADDR_WIDTH, 4, AXI byte-address width.
- NUM_REGS, 4, number of implemented word registers; must be at most 2^(ADDR_WIDTH-2).

Ports:
- S_AXI_ACLK  in  1  single clock.
- S_AXI_ARESETN  in  1  asynchronous active-low reset.
- S_AXI_AWADDR  in  ADDR_WIDTH  write address.
- S_AXI_AWPROT  in  3  ignored.
- S_AXI_AWVALID  in  1 / S_AXI_AWREADY  out  1.
- S_AXI_WDATA  in  DATA_WIDTH / S_AXI_WSTRB  in  DATA_WIDTH/8 / S_AXI_WVALID  in  1 / S_AXI_WREADY  out  1.
- S_AXI_BRESP  out  2 / S_AXI_BVALID  out  1 / S_AXI_BREADY  in  1.
- S_AXI_ARADDR  in  ADDR_WIDTH / S_AXI_ARPROT  in  3 (ignored) / S_AXI_ARVALID  in  1 / S_AXI_ARREADY  out  1.
- S_AXI_RDATA  out  DATA_WIDTH / S_AXI_RRESP  out  2 / S_AXI_RVALID  out  1 / S_AXI_RREADY  in  1.
- reg_out  out  NUM_REGS*DATA_WIDTH  register contents; register k is at bits [k*32 +: 32].

Behaviour:
- Reset (ARESETN=0, asynchronous):
  - all registers = 0.
  - all READY/VALID outputs = 0; BRESP = RRESP = 00; RDATA = 0.
  - both FSMs go to IDLE.
  - AWREADY, WREADY and ARREADY are registered; they rise on the first clock edge after ARESETN deasserts.
  - Reset mid-transaction aborts it; no response is issued.
- Decode: word index = addr[ADDR_WIDTH-1:2]; addr[1:0] is ignored. Index >= NUM_REGS is out of range.
- Write FSM, W_IDLE:
  - AWREADY=1 until AW is captured; WREADY=1 until W is captured.
  - AW and W are accepted independently, in either order or in the same cycle.
  - On the edge where both are held: commit the write and move to W_RESP.
  - Commit rule: each byte lane with WSTRB set is updated. Out-of-range writes change nothing.
- Write FSM, W_RESP:
  - BVALID=1, AWREADY=WREADY=0.
  - BRESP = 00 (OKAY), or 10 (SLVERR) if the index was out of range.
  - BVALID stays high until BREADY; on the handshake edge return to W_IDLE with both readies high the next cycle.
- Write latency: AW and W together in cycle 0 -> reg_out updated and BVALID high in cycle 1.
- Read FSM, R_IDLE:
  - ARREADY=1. On the ARVALID handshake, register RDATA from the addressed register and move to R_DATA.
  - Out-of-range read: RDATA = 0, RRESP = 10.
- Read FSM, R_DATA:
  - RVALID=1, ARREADY=0.
  - RDATA/RRESP are held stable until the RREADY handshake, then return to R_IDLE.
- Read latency: 1 cycle from AR handshake to RVALID.
- Read/write collision: a read handshaking on the same edge as a write commit to the same register returns the pre-write value. A later read returns the new value.
- Back-pressure: BREADY or RREADY held low indefinitely stalls only its own channel; the other channel keeps operating.

Optional Feature:
- Macro AXI_VGA_REG_WR_STROBE_EN.
- Defined:
  - adds output port wr_strobe [NUM_REGS-1:0].
  - Bit k pulses high for exactly one cycle, the cycle after an in-range commit to register k (aligned with the first BVALID cycle).
  - Resets to 0. Lets the VGA side latch cursor moves and similar events.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Sequential writes then reads: write 0x1, 0x2, 0x3, 0x4 to addresses 0x0, 0x4, 0x8, 0xC, each with BRESP=00. Read back the same addresses -> RDATA 0x1..0x4, RRESP=00; reg_out = 0x00000004_00000003_00000002_00000001.
- Staggered write channels: W (0xAABBCCDD) issued 3 cycles before AW (0x8) -> WREADY drops after W capture, BVALID only after AW; reg2 = 0xAABBCCDD.
- Byte strobes: reg1 = 0x11223344, then write 0xFFFFFFFF to 0x4 with WSTRB=0101 -> read 0x4 returns 0x11FF33FF.
- Out of range: with NUM_REGS=3, write 0x5 to 0xC -> BRESP=10 and registers unchanged; read 0xC -> RDATA=0, RRESP=10.
- Back-pressure and concurrency:
  - Hold BREADY=0 for 5 cycles -> BVALID stays high and AWREADY=0.
  - Meanwhile a read of 0x0 completes normally.
  - Same-edge read and write of 0x0 (old value 0x1, new 0x9) -> read returns 0x1; the next read returns 0x9.
- Reset mid-transaction: assert ARESETN=0 while BVALID=1 -> BVALID and registers go to 0 immediately (asynchronously). ARREADY is 1 one edge after release. With the macro defined, wr_strobe is 0.
